// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the Booth multiplier controller
package mult_pkg;

    localparam int WIDTH   = 32;
    localparam int ITER    = 32;
    localparam int COUNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the {lo[0], q} pair.
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        booth_op_t op;
        case (pair)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_PASS;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cla_32.sv
// rtl/cla_32.sv - 32-bit carry-lookahead adder with signed overflow
module cla_32 (
    output logic [31:0] sum,
    output logic        overflow,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] carries;
    logic        cy;

    assign g = a & b;
    assign p = a ^ b;

    // Four-bit lookahead groups; the group carry ripples between groups.
    always_comb begin
        carries = '0;
        cy      = c_in;
        for (int k = 0; k < 8; k++) begin
            carries[4*k]   = cy;
            carries[4*k+1] = g[4*k] | (p[4*k] & cy);
            carries[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cy);
            carries[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                           | (p[4*k+2] & p[4*k+1] & p[4*k] & cy);
            cy = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & cy);
        end
    end

    assign sum      = p ^ carries;
    assign overflow = cy ^ carries[31];

endmodule

// File: rtl/booth_mult_ctrl.sv
// rtl/booth_mult_ctrl.sv - multi-cycle signed 32x32 radix-2 Booth multiplier controller
module booth_mult_ctrl #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             data_ready,
    output logic             busy
);
    import mult_pkg::*;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   p_hi;
    logic [WIDTH-1:0]   p_lo;
    logic               p_q;
    logic [COUNT_W-1:0] count;
    booth_op_t          op;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   sum;
    logic               ovf;
    logic               sign_bit;
    logic               last_iter;

    assign last_iter = (count == COUNT_W'(ITER - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ctrl_start) next_state = RUN;
            RUN:     if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign op = booth_decode({p_lo[0], p_q});

    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        case (op)
            OP_ADD: add_b = m_reg;
            OP_SUB: begin
                add_b   = ~m_reg;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    cla_32 u_adder (
        .sum      (sum),
        .overflow (ovf),
        .a        (p_hi),
        .b        (add_b),
        .c_in     (add_cin)
    );

    // The adder only yields 32 bits; the true 33rd bit is recovered from overflow.
    assign sign_bit = sum[WIDTH-1] ^ ovf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_reg <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            p_q   <= 1'b0;
            count <= '0;
        end else if (state == IDLE && ctrl_start) begin
            m_reg <= operand_a;
            p_hi  <= '0;
            p_lo  <= operand_b;
            p_q   <= 1'b0;
            count <= '0;
        end else if (state == RUN) begin
            p_hi  <= {sign_bit, sum[WIDTH-1:1]};
            p_lo  <= {sum[0], p_lo[WIDTH-1:1]};
            p_q   <= p_lo[0];
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result     <= '0;
            exception  <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_ready <= (state == DONE);
            busy       <= (next_state != IDLE);
            if (state == DONE) begin
                result    <= p_lo;
                exception <= (p_hi != {WIDTH{p_lo[WIDTH-1]}});
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb/tb_booth_mult_ctrl.sv - scoreboard bench for booth_mult_ctrl
module tb_booth_mult_ctrl;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_start;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        exception;
    logic        data_ready;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   ready_count = 0;
    exp_t sb[$];
    logic [31:0] edge_vals [6];

    booth_mult_ctrl #(.WIDTH(32), .ITER(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ctrl_start (ctrl_start),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result     (result),
        .exception  (exception),
        .data_ready (data_ready),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (data_ready === 1'b1) ready_count++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] prod;
        exp_t r;
        prod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r.res = prod[31:0];
        r.exc = (prod[63:32] != {32{prod[31]}});
        return r;
    endfunction

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic ee,
                           input int intr_at, input logic [31:0] ia, input logic [31:0] ib);
        int   w;
        int   e;
        int   rc0;
        exp_t got;
        w = 0;
        while (busy && w < 100) begin
            @(negedge clock);
            w++;
        end
        operand_a  = a;
        operand_b  = b;
        ctrl_start = 1'b1;
        sb.push_back('{er, ee});
        rc0 = ready_count;
        @(posedge clock);
        @(negedge clock);
        ctrl_start = 1'b0;
        operand_a  = $urandom;
        operand_b  = $urandom;
        check("busy_run", 64'(busy), 64'd1);
        e = 0;
        while (!data_ready && e < 60) begin
            if (e == intr_at) begin
                operand_a  = ia;
                operand_b  = ib;
                ctrl_start = 1'b1;
            end
            @(posedge clock);
            e++;
            @(negedge clock);
            ctrl_start = 1'b0;
        end
        check("latency", 64'(e), 64'd33);
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd0, 64'd1);
        end else begin
            got = sb.pop_front();
            if (data_ready) begin
                check("result", 64'(result), 64'(got.res));
                check("exception", 64'(exception), 64'(got.exc));
            end
        end
        check("busy_ready", 64'(busy), 64'd0);
        @(negedge clock);
        check("ready_pulse_width", 64'(data_ready), 64'd0);
        check("result_hold", 64'(result), 64'(er));
        check("pulse_count", 64'(ready_count - rc0), 64'd1);
    endtask

    initial begin
        exp_t m;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rc0;

        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'h0000_0001;
        edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = 32'h7FFF_FFFF;
        edge_vals[4] = 32'h8000_0000;
        edge_vals[5] = 32'h0001_0000;

        reset_n    = 1'b0;
        ctrl_start = 1'b0;
        operand_a  = '0;
        operand_b  = '0;
        repeat (3) @(negedge clock);
        check("rst_result", 64'(result), 64'd0);
        check("rst_exception", 64'(exception), 64'd0);
        check("rst_ready", 64'(data_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_ready", 64'(data_ready), 64'd0);

        do_mult(32'd3, 32'd5, 32'h0000_000F, 1'b0, -1, '0, '0);
        do_mult(32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, -1, '0, '0);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, -1, '0, '0);
        do_mult(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, -1, '0, '0);
        do_mult(32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, -1, '0, '0);
        do_mult(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, -1, '0, '0);
        do_mult(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, -1, '0, '0);
        do_mult(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, -1, '0, '0);

        // Start during RUN must be ignored entirely.
        do_mult(32'd3, 32'd5, 32'h0000_000F, 1'b0, 10, 32'd9, 32'd9);
        rc0 = ready_count;
        repeat (40) @(negedge clock);
        check("ignored_start_pulses", 64'(ready_count - rc0), 64'd0);
        check("ignored_start_result", 64'(result), 64'h0000_000F);
        check("ignored_start_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of RUN.
        operand_a  = 32'd12;
        operand_b  = 32'd12;
        ctrl_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_start = 1'b0;
        repeat (10) @(negedge clock);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_result", 64'(result), 64'd0);
        check("async_rst_exception", 64'(exception), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_ready", 64'(data_ready), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rc0 = ready_count;
        repeat (40) @(negedge clock);
        check("post_reset_pulses", 64'(ready_count - rc0), 64'd0);
        check("post_reset_result", 64'(result), 64'd0);
        do_mult(32'd2, 32'd2, 32'd4, 1'b0, -1, '0, '0);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    ra = $urandom;
                    rb = $urandom;
                end
                1: begin
                    ra = 32'($signed($urandom_range(0, 200)) - 100);
                    rb = 32'($signed($urandom_range(0, 200)) - 100);
                end
                2: begin
                    ra = edge_vals[$urandom_range(0, 5)];
                    rb = edge_vals[$urandom_range(0, 5)];
                end
                default: begin
                    ra = $urandom >> $urandom_range(0, 31);
                    rb = edge_vals[$urandom_range(0, 5)] ^ ($urandom >> $urandom_range(16, 31));
                end
            endcase
            m = model(ra, rb);
            do_mult(ra, rb, m.res, m.exc, -1, '0, '0);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mult_ctrl.md
Name: booth_mult_ctrl

Overview:
- Multi-cycle signed 32x32 multiplier controller built around a single shared cla_32 adder instance.
- Sequences radix-2 Booth iterations: one add/subtract/pass per cycle.
- Returns the low 32 bits of the product plus an overflow exception flag.
- Sits beside the ALU in the execute stage; the pipeline stalls on `busy` until `data_ready`.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported because the datapath is cla_32.
- ITER, 32, number of Booth iterations; must equal WIDTH.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ctrl_start  in  1  start request; sampled only in IDLE.
- operand_a  in  32  multiplicand, two's complement; latched on accepted start.
- operand_b  in  32  multiplier, two's complement; latched on accepted start.
- result  out  32  product[31:0]; held until the next accepted start.
- exception  out  1  1 when the signed 64-bit product does not fit in 32 bits; held with result.
- data_ready  out  1  one-cycle pulse marking result/exception valid.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; result=0, exception=0, data_ready=0, busy=0.
  - Internal registers and counter cleared.
  - Reset mid-operation aborts it; no data_ready pulse is issued.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On ctrl_start=1: latch M=operand_a; P={hi=0, lo=operand_b, q=0} (65-bit product register, q is the extra Booth bit); count=0; go to RUN.
  - result/exception keep their previous values.
- RUN (exactly 32 cycles, count 0..31):
  - Booth pair {lo[0],q}: 00/11 pass (cla_32 a=hi, b=0, c_in=0); 01 add (b=M, c_in=0); 10 subtract (b=~M, c_in=1).
  - True 33rd sign bit of the sum is s = sum[31]^overflow; this holds for add, subtract and pass.
  - P <= arithmetic shift right of {s, sum, lo, q} by one, dropping the old q.
  - count++; after count=31, go to DONE.
- DONE (1 cycle):
  - data_ready=1; result=P.lo.
  - exception=1 iff P.hi != {32{P.lo[31]}}.
  - busy=1 this cycle; next state IDLE.
- Latency: start accepted at edge N; data_ready high in the cycle after edge N+33, i.e. 33 clocks start-to-ready; back-to-back throughput 34 clocks.
- ctrl_start while busy (RUN or DONE) is ignored, with no effect on operands or sequence. ctrl_start in the same cycle as DONE is also ignored; the requester re-asserts in IDLE.
- Operand inputs are don't-care except in the cycle an accepted start is sampled.
- The adder's overflow output is never exported directly; it is used only to form s.
- Corner cases:
  - operand_a=0x80000000: subtracting M (adding +2^31) is correct via s.
  - 0x80000000 x 0x80000000 = 2^62: result 0, exception 1.
- Outputs are registered; data_ready is a registered decode of DONE.

Decomposition:
- Package mult_pkg:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - WIDTH=32, ITER=32, COUNT_W=5.
  - Booth op codes: PASS, ADD, SUB.
- Sub-module: the existing cla_32 (sum, overflow, a, b, c_in), instantiated once; no new adder.
- Operand mux (0/M/~M) and c_in select stay inline in booth_mult_ctrl.

Test Plan:
- 3 x 5, start pulsed one cycle -> 33 clocks later data_ready=1 for exactly one cycle; result=0x0000000F, exception=0; busy drops the following cycle.
- -7 (0xFFFFFFF9) x 6 -> result=0xFFFFFFD6, exception=0; -1 x -1 -> result=0x00000001, exception=0.
- Overflow cases:
  - 0x80000000 x 0x80000000 -> result=0x00000000, exception=1.
  - 0x7FFFFFFF x 2 -> result=0xFFFFFFFE, exception=1.
  - 0x00010000 x 0x00010000 -> result=0, exception=1.
- Start 3 x 5, then at RUN count=10 pulse ctrl_start with 9 x 9 -> result=15 at the original timing; no second data_ready; result stays 15 until a new start in IDLE.
- Start 12 x 12, assert reset_n=0 asynchronously mid-RUN -> outputs immediately 0, busy=0. After release, 2 x 2 gives result=4 after 33 clocks with no stale pulse.
- Random signed pairs (>=1000) compared against a 64-bit reference model: result equals the low 32 bits; exception equals (hi != sign extension of bit 31).
